// File: rtl/simplerisc_pkg.sv
// -----------------------------------------------------------------------------
// simplerisc_pkg
// Shared types and constants for the SimpleRISC multi-cycle control path:
//   state_e          sequencer state encoding
//   OP_*             opcodes the sequencer treats specially
//   WB_*             register-file write-back source select encodings
//   PC_*             next-PC source select encodings
//   is_long_op()     true for opcodes that run on the multi-cycle divider
// -----------------------------------------------------------------------------
package simplerisc_pkg;

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      FAULT  = 3'd5
   } state_e;

   localparam logic [4:0] OP_DIV  = 5'b00011;
   localparam logic [4:0] OP_MOD  = 5'b00100;
   localparam logic [4:0] OP_CMP  = 5'b00101;
   // Highest defined opcode; anything above it is illegal.
   localparam logic [4:0] OP_LAST = 5'b10100;

   localparam logic [1:0] WB_ALU  = 2'd0;
   localparam logic [1:0] WB_LOAD = 2'd1;
   localparam logic [1:0] WB_PC4  = 2'd2;

   localparam logic [1:0] PC_PLUS4  = 2'd0;
   localparam logic [1:0] PC_BRANCH = 2'd1;
   localparam logic [1:0] PC_RET    = 2'd2;

   function automatic logic is_long_op(input logic [4:0] op);
      return (op == OP_DIV) || (op == OP_MOD);
   endfunction

endpackage

// File: rtl/simplerisc_branch_resolve.sv
// -----------------------------------------------------------------------------
// simplerisc_branch_resolve
// Combinational next-PC source selection for the retire cycle.
// Ports:
//   is_ret, is_ubranch, is_call, is_beq, is_bgt  decoded flags of current IR
//   flag_e, flag_gt                              architectural (registered) flags
//   pc_sel                                       PC_RET / PC_BRANCH / PC_PLUS4
// -----------------------------------------------------------------------------
module simplerisc_branch_resolve
   import simplerisc_pkg::*;
(
   input  logic       is_ret,
   input  logic       is_ubranch,
   input  logic       is_call,
   input  logic       is_beq,
   input  logic       is_bgt,
   input  logic       flag_e,
   input  logic       flag_gt,
   output logic [1:0] pc_sel
);

   always_comb begin
      pc_sel = PC_PLUS4;
      if (is_ret) begin
         pc_sel = PC_RET;
      end else if (is_ubranch || is_call || (is_beq && flag_e) || (is_bgt && flag_gt)) begin
         pc_sel = PC_BRANCH;
      end
   end

endmodule

// File: rtl/simplerisc_multicycle_sequencer.sv
// -----------------------------------------------------------------------------
// simplerisc_multicycle_sequencer
// Multi-cycle control FSM for SimpleRISC: FETCH -> DECODE -> EXEC -> [MEM] ->
// [WB], with memory handshakes, divider start/wait, condition flags and the
// PC/IR/register-file write strobes. A memory wait longer than MEM_TIMEOUT
// cycles, or an illegal opcode, parks the sequencer in FAULT until reset.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   ir_opcode, is_*             current instruction opcode and decoded flags
//   alu_flag_e, alu_flag_gt     compare results, sampled at cmp EXEC exit
//   alu_done                    divider completion pulse
//   imem_ack, dmem_ack          memory acknowledge pulses
//   imem_req, dmem_req, dmem_we memory requests (dmem_we = store)
//   ir_we, alu_start, rf_we     IR load, divider start, register write
//   wb_sel, pc_we, pc_sel       write-back source, PC update and source
//   flag_e, flag_gt             architectural flags
//   instr_retired, fault        retire pulse, sticky fault
// -----------------------------------------------------------------------------
module simplerisc_multicycle_sequencer
   import simplerisc_pkg::*;
#(
   parameter int MEM_TIMEOUT = 255,
   parameter int TMO_W       = 8
)(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [4:0] ir_opcode,
   input  logic       is_ret,
   input  logic       is_st,
   input  logic       is_wb,
   input  logic       is_beq,
   input  logic       is_bgt,
   input  logic       is_ubranch,
   input  logic       is_ld,
   input  logic       is_call,
   input  logic       alu_flag_e,
   input  logic       alu_flag_gt,
   input  logic       alu_done,
   input  logic       imem_ack,
   input  logic       dmem_ack,
   output logic       imem_req,
   output logic       dmem_req,
   output logic       dmem_we,
   output logic       ir_we,
   output logic       alu_start,
   output logic       rf_we,
   output logic [1:0] wb_sel,
   output logic       pc_we,
   output logic [1:0] pc_sel,
   output logic       flag_e,
   output logic       flag_gt,
   output logic       instr_retired,
   output logic       fault
);

   state_e           state, state_nx;
   logic             armed;       // low during reset and until the first edge after release
   logic             exec_first;  // first cycle of EXEC
   logic [TMO_W-1:0] tmo_cnt;
   logic             tmo_expired;
   logic             waiting;
   logic             retire;
   logic             load_flags;
   logic [1:0]       br_sel;

   simplerisc_branch_resolve u_branch_resolve (
      .is_ret     (is_ret),
      .is_ubranch (is_ubranch),
      .is_call    (is_call),
      .is_beq     (is_beq),
      .is_bgt     (is_bgt),
      .flag_e     (flag_e),
      .flag_gt    (flag_gt),
      .pc_sel     (br_sel)
   );

   // The final permitted waiting cycle: an ack here is still honoured,
   // otherwise the request is abandoned at this edge.
   assign tmo_expired = (tmo_cnt == TMO_W'(MEM_TIMEOUT - 1));

   always_comb begin
      state_nx   = state;
      imem_req   = 1'b0;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      ir_we      = 1'b0;
      alu_start  = 1'b0;
      rf_we      = 1'b0;
      wb_sel     = WB_ALU;
      fault      = 1'b0;
      waiting    = 1'b0;
      retire     = 1'b0;
      load_flags = 1'b0;
      // Gating on armed keeps every output low while reset is held, since the
      // reset state is FETCH and would otherwise raise imem_req immediately.
      if (armed) begin
         case (state)
            FETCH: begin
               imem_req = 1'b1;
               if (imem_ack) begin
                  ir_we    = 1'b1;
                  state_nx = DECODE;
               end else begin
                  waiting = 1'b1;
                  if (tmo_expired) state_nx = FAULT;
               end
            end
            DECODE: begin
               state_nx = (ir_opcode > OP_LAST) ? FAULT : EXEC;
            end
            EXEC: begin
               alu_start = is_long_op(ir_opcode) && exec_first;
               if (!is_long_op(ir_opcode) || alu_done) begin
                  load_flags = (ir_opcode == OP_CMP);
                  if (is_ld || is_st) begin
                     state_nx = MEM;
                  end else if (is_wb) begin
                     state_nx = WB;
                  end else begin
                     retire   = 1'b1;
                     state_nx = FETCH;
                  end
               end
            end
            MEM: begin
               dmem_req = 1'b1;
               dmem_we  = is_st;
               if (dmem_ack) begin
                  if (is_st) begin
                     retire   = 1'b1;
                     state_nx = FETCH;
                  end else begin
                     state_nx = WB;
                  end
               end else begin
                  waiting = 1'b1;
                  if (tmo_expired) state_nx = FAULT;
               end
            end
            WB: begin
               rf_we    = 1'b1;
               wb_sel   = is_call ? WB_PC4 : (is_ld ? WB_LOAD : WB_ALU);
               retire   = 1'b1;
               state_nx = FETCH;
            end
            FAULT: begin
               fault = 1'b1;
            end
            default: begin
               state_nx = FAULT;
            end
         endcase
      end
      pc_we         = retire;
      instr_retired = retire;
      pc_sel        = retire ? br_sel : PC_PLUS4;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= FETCH;
         armed      <= 1'b0;
         exec_first <= 1'b0;
         tmo_cnt    <= '0;
         flag_e     <= 1'b0;
         flag_gt    <= 1'b0;
      end else begin
         armed      <= 1'b1;
         state      <= state_nx;
         exec_first <= (state == DECODE) && (state_nx == EXEC);
         if ((state_nx != state) && ((state_nx == FETCH) || (state_nx == MEM))) begin
            tmo_cnt <= '0;
         end else if (waiting) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
         end
         if (load_flags) begin
            flag_e  <= alu_flag_e;
            flag_gt <= alu_flag_gt;
         end
      end
   end

endmodule

// File: tb/tb_simplerisc_multicycle_sequencer.sv
// -----------------------------------------------------------------------------
// tb_simplerisc_multicycle_sequencer
// Drives one instruction at a time with programmable memory/divider latencies,
// queues the expected retire result per instruction and checks it when the
// sequencer retires; then exercises timeout, illegal-opcode and reset cases.
// -----------------------------------------------------------------------------
module tb_simplerisc_multicycle_sequencer;

   localparam int TMO = 4;

   localparam logic [7:0] F_NONE = 8'h00;
   localparam logic [7:0] F_RET  = 8'h80;
   localparam logic [7:0] F_ST   = 8'h40;
   localparam logic [7:0] F_WB   = 8'h20;
   localparam logic [7:0] F_BEQ  = 8'h10;
   localparam logic [7:0] F_BGT  = 8'h08;
   localparam logic [7:0] F_UB   = 8'h04;
   localparam logic [7:0] F_LD   = 8'h02;
   localparam logic [7:0] F_CALL = 8'h01;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [4:0] ir_opcode = '0;
   logic       is_ret = 0, is_st = 0, is_wb = 0, is_beq = 0;
   logic       is_bgt = 0, is_ubranch = 0, is_ld = 0, is_call = 0;
   logic       alu_flag_e = 0, alu_flag_gt = 0, alu_done = 0;
   logic       imem_ack = 0, dmem_ack = 0;
   logic       imem_req, dmem_req, dmem_we, ir_we, alu_start, rf_we;
   logic [1:0] wb_sel, pc_sel;
   logic       pc_we, flag_e, flag_gt, instr_retired, fault;
   logic [14:0] outs;

   assign outs = {imem_req, dmem_req, dmem_we, ir_we, alu_start, rf_we, wb_sel,
                  pc_we, pc_sel, flag_e, flag_gt, instr_retired, fault};

   always #5 clk = ~clk;

   simplerisc_multicycle_sequencer #(.MEM_TIMEOUT(TMO), .TMO_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .ir_opcode(ir_opcode),
      .is_ret(is_ret), .is_st(is_st), .is_wb(is_wb), .is_beq(is_beq),
      .is_bgt(is_bgt), .is_ubranch(is_ubranch), .is_ld(is_ld), .is_call(is_call),
      .alu_flag_e(alu_flag_e), .alu_flag_gt(alu_flag_gt), .alu_done(alu_done),
      .imem_ack(imem_ack), .dmem_ack(dmem_ack),
      .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we), .ir_we(ir_we),
      .alu_start(alu_start), .rf_we(rf_we), .wb_sel(wb_sel), .pc_we(pc_we),
      .pc_sel(pc_sel), .flag_e(flag_e), .flag_gt(flag_gt),
      .instr_retired(instr_retired), .fault(fault)
   );

   typedef struct {
      int         cyc;
      logic [1:0] pc;
      logic       rf;
      logic [1:0] wb;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, want %0h", tag, got, exp);
      end
   endtask

   task automatic set_flags(input logic [7:0] fl);
      {is_ret, is_st, is_wb, is_beq, is_bgt, is_ubranch, is_ld, is_call} = fl;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      imem_ack = 0; dmem_ack = 0; alu_done = 0;
      repeat (2) @(posedge clk);
      #1 check("rst.outs", 32'(outs), 32'h0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1 check("rst.imem_req", 32'(imem_req), 32'h1);
   endtask

   // Entered just after a clock edge with the sequencer in FETCH.
   task automatic run_instr(input string nm, input logic [4:0] op, input logic [7:0] fl,
                            input logic ae, input logic agt,
                            input int ilat, input int dlat, input int alat, input bit noise,
                            input int ecyc, input logic [1:0] epc, input logic erf,
                            input logic [1:0] ewb, input logic efe, input logic efgt);
      exp_t e;
      int   cyc = 0, wi = 0, wd = 0, dc = 0;
      bit   done = 0, darm = 0;
      int   irwe_cyc = -1, irwe_n = 0, start_n = 0, dreq_n = 0, dwe_n = 0, rfwe_n = 0, early = 0;
      bit   long_op;
      long_op = (op == 5'b00011) || (op == 5'b00100);
      set_flags(fl);
      ir_opcode = op; alu_flag_e = ae; alu_flag_gt = agt;
      e.cyc = ecyc; e.pc = epc; e.rf = erf; e.wb = ewb;
      sb.push_back(e);
      while (!done && cyc < 100) begin
         @(negedge clk);
         cyc++;
         imem_ack = imem_req ? (wi == ilat) : noise;
         dmem_ack = dmem_req ? (wd == dlat) : noise;
         alu_done = darm && (dc == alat);
         #1;
         if (ir_we) begin irwe_n++; if (irwe_cyc < 0) irwe_cyc = cyc; end
         if (imem_req && !imem_ack) wi++;
         if (dmem_req && !dmem_ack) wd++;
         if (dmem_req) begin dreq_n++; if (dmem_we) dwe_n++; end
         if (rf_we) rfwe_n++;
         if ((rf_we || pc_we) && !instr_retired) early++;
         if (alu_done) darm = 0;
         if (alu_start) begin start_n++; darm = 1; dc = 0; end
         if (darm) dc++;
         if (instr_retired) begin
            done = 1;
            e = sb.pop_front();
            check({nm, ".cycles"}, 32'(cyc), 32'(e.cyc));
            check({nm, ".pc_we"}, 32'(pc_we), 32'h1);
            check({nm, ".pc_sel"}, 32'(pc_sel), 32'(e.pc));
            check({nm, ".rf_we"}, 32'(rf_we), 32'(e.rf));
            if (e.rf) check({nm, ".wb_sel"}, 32'(wb_sel), 32'(e.wb));
         end
         @(posedge clk);
         #1 imem_ack = 0; dmem_ack = 0; alu_done = 0;
      end
      if (!done) begin
         check({nm, ".retired"}, 32'h0, 32'h1);
         if (sb.size() > 0) sb.delete(0);
      end
      check({nm, ".ir_we_cycle"}, 32'(irwe_cyc), 32'(ilat + 1));
      check({nm, ".ir_we_count"}, 32'(irwe_n), 32'h1);
      check({nm, ".alu_starts"}, 32'(start_n), 32'(long_op ? 1 : 0));
      check({nm, ".dmem_req_cycles"}, 32'(dreq_n), 32'((fl & (F_LD | F_ST)) != 0 ? dlat + 1 : 0));
      check({nm, ".dmem_we_cycles"}, 32'(dwe_n), 32'((fl & F_ST) != 0 ? dlat + 1 : 0));
      check({nm, ".rf_we_count"}, 32'(rfwe_n), 32'(erf));
      check({nm, ".strobe_outside_retire"}, 32'(early), 32'h0);
      check({nm, ".flag_e"}, 32'(flag_e), 32'(efe));
      check({nm, ".flag_gt"}, 32'(flag_gt), 32'(efgt));
      check({nm, ".fault"}, 32'(fault), 32'h0);
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: got no finish, want finish");
      $fatal(1);
   end

   initial begin
      int n;
      int fc;
      int strobes;
      bit seen;
      logic [4:0] badop [2];

      do_reset();

      //        name         op        flags        ae agt ilat dlat alat nz cyc pc rf wb fe fgt
      run_instr("add",       5'b00000, F_WB,         0, 0,  0,   0,   0, 0,  4, 0, 1, 0, 0, 0);
      run_instr("add_noise", 5'b00001, F_WB,         0, 0,  0,   0,   0, 1,  4, 0, 1, 0, 0, 0);
      run_instr("cmp_eq",    5'b00101, F_NONE,       1, 0,  0,   0,   0, 0,  3, 0, 0, 0, 1, 0);
      run_instr("beq_taken", 5'b01000, F_BEQ,        0, 0,  0,   0,   0, 0,  3, 1, 0, 0, 1, 0);
      run_instr("bgt_not",   5'b01001, F_BGT,        0, 1,  0,   0,   0, 0,  3, 0, 0, 0, 1, 0);
      run_instr("cmp_ne",    5'b00101, F_NONE,       0, 0,  0,   0,   0, 0,  3, 0, 0, 0, 0, 0);
      run_instr("beq_not",   5'b01000, F_BEQ,        1, 0,  0,   0,   0, 0,  3, 0, 0, 0, 0, 0);
      run_instr("cmp_gt",    5'b00101, F_NONE,       0, 1,  0,   0,   0, 0,  3, 0, 0, 0, 0, 1);
      run_instr("bgt_taken", 5'b01001, F_BGT,        1, 0,  0,   0,   0, 0,  3, 1, 0, 0, 0, 1);
      run_instr("beq_not2",  5'b01000, F_BEQ,        0, 0,  0,   0,   0, 0,  3, 0, 0, 0, 0, 1);
      run_instr("ld_wait3",  5'b01110, F_LD | F_WB,  0, 0,  0,   3,   0, 1,  8, 0, 1, 1, 0, 1);
      run_instr("st",        5'b01111, F_ST,         0, 0,  0,   0,   0, 0,  4, 0, 0, 0, 0, 1);
      run_instr("st_wait2",  5'b01111, F_ST,         0, 0,  0,   2,   0, 0,  6, 0, 0, 0, 0, 1);
      run_instr("call",      5'b10010, F_CALL | F_WB,0, 0,  0,   0,   0, 0,  4, 1, 1, 2, 0, 1);
      run_instr("ret",       5'b10011, F_RET,        0, 0,  0,   0,   0, 0,  3, 2, 0, 0, 0, 1);
      run_instr("div",       5'b00011, F_WB,         0, 0,  0,   0,  10, 0, 14, 0, 1, 0, 0, 1);
      run_instr("mod",       5'b00100, F_WB,         0, 0,  0,   0,   2, 0,  6, 0, 1, 0, 0, 1);
      run_instr("ub_oplast", 5'b10100, F_UB,         0, 0,  0,   0,   0, 0,  3, 1, 0, 0, 0, 1);
      run_instr("nop_iwait3",5'b00000, F_NONE,       0, 0,  3,   0,   0, 0,  6, 0, 0, 0, 0, 1);

      // Instruction fetch never acknowledged.
      do_reset();
      n = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         imem_ack = 0;
         #1 if (imem_req) n++;
      end
      check("tmo.req_cycles", 32'(n), 32'(TMO));
      check("tmo.fault", 32'(fault), 32'h1);
      check("tmo.imem_req", 32'(imem_req), 32'h0);
      @(negedge clk);
      imem_ack = 1; dmem_ack = 1; alu_done = 1;
      @(posedge clk);
      #1 check("tmo.hold", 32'(outs), 32'h1);
      imem_ack = 0; dmem_ack = 0; alu_done = 0;

      // Illegal opcodes, including the first one past the last legal opcode.
      badop[0] = 5'b11000;
      badop[1] = 5'b10101;
      for (int k = 0; k < 2; k++) begin
         do_reset();
         ir_opcode = badop[k];
         set_flags(F_WB);
         fc = -1;
         strobes = 0;
         for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            imem_ack = imem_req;
            #1;
            if (rf_we || pc_we || instr_retired || alu_start || dmem_req) strobes++;
            if (fault && fc < 0) fc = c;
            @(posedge clk);
            #1 imem_ack = 0;
         end
         check($sformatf("badop%0d.fault_cycle", k), 32'(fc), 32'h3);
         check($sformatf("badop%0d.strobes", k), 32'(strobes), 32'h0);
      end

      // Reset asserted while a load waits in MEM.
      do_reset();
      ir_opcode = 5'b01110;
      set_flags(F_LD | F_WB);
      seen = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         imem_ack = imem_req;
         #1;
         if (dmem_req) begin
            seen = 1;
            break;
         end
         @(posedge clk);
         #1 imem_ack = 0;
      end
      imem_ack = 0;
      check("rstmem.reached_mem", 32'(seen), 32'h1);
      #1 rst_n = 1'b0;
      #1;
      check("rstmem.dmem_req", 32'(dmem_req), 32'h0);
      check("rstmem.outs", 32'(outs), 32'h0);

      do_reset();
      run_instr("add_after_rst", 5'b00000, F_WB, 0, 0, 0, 0, 0, 0, 4, 0, 1, 0, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
